// File: rtl/elbeth_mem_arbiter_pkg.sv
// Shared types and defaults for the ELBETH RAM-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package elbeth_mem_arbiter_pkg;

   localparam int MARB_AW      = 14;   // RAM word-address width
   localparam int MARB_DW      = 32;   // RAM word width
   localparam int MARB_SW      = 4;    // byte strobes per word
   localparam int MARB_TIMEOUT = 15;   // WAIT cycles before giving up on the RAM

   // Arbiter FSM states; 2-bit encoding shared with the rest of the ELBETH core.
   typedef enum logic [1:0] {
      MARB_IDLE  = 2'd0,
      MARB_ISSUE = 2'd1,
      MARB_WAIT  = 2'd2,
      MARB_RESP  = 2'd3
   } marb_state_e;

   // Width of a counter that must be able to hold the value 'timeout'.
   function automatic int marb_cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/elbeth_mem_arbiter_if.sv
// Bundle of the two requester ports and the shared RAM port.
// Latency: n/a (wires only).
// Backpressure: requesters hold mX_enable until mX_ready; the RAM never stalls the enable.
interface elbeth_mem_arbiter_if
   import elbeth_mem_arbiter_pkg::*;
#(
   parameter int AW = MARB_AW
);

   // requester 0: CPU data side
   logic               m0_enable;
   logic [AW-1:0]      m0_addr;
   logic [MARB_DW-1:0] m0_data_in;
   logic [MARB_SW-1:0] m0_rw;
   logic [MARB_DW-1:0] m0_data_out;
   logic               m0_ready;
   logic               m0_error;

   // requester 1: loader / debug
   logic               m1_enable;
   logic [AW-1:0]      m1_addr;
   logic [MARB_DW-1:0] m1_data_in;
   logic [MARB_SW-1:0] m1_rw;
   logic [MARB_DW-1:0] m1_data_out;
   logic               m1_ready;
   logic               m1_error;

   // shared RAM port
   logic               mem_enable;
   logic [AW-1:0]      mem_addr;
   logic [MARB_DW-1:0] mem_data_in;
   logic [MARB_SW-1:0] mem_rw;
   logic [MARB_DW-1:0] mem_data_out;
   logic               mem_ready;

   // Arbiter view: masters the RAM port, serves both requesters.
   modport master (
      input  m0_enable, m0_addr, m0_data_in, m0_rw,
      output m0_data_out, m0_ready, m0_error,
      input  m1_enable, m1_addr, m1_data_in, m1_rw,
      output m1_data_out, m1_ready, m1_error,
      output mem_enable, mem_addr, mem_data_in, mem_rw,
      input  mem_data_out, mem_ready
   );

   // Environment view: the requesters and the RAM.
   modport slave (
      output m0_enable, m0_addr, m0_data_in, m0_rw,
      input  m0_data_out, m0_ready, m0_error,
      output m1_enable, m1_addr, m1_data_in, m1_rw,
      input  m1_data_out, m1_ready, m1_error,
      input  mem_enable, mem_addr, mem_data_in, mem_rw,
      output mem_data_out, mem_ready
   );

endinterface

// File: rtl/elbeth_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not granted last.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module elbeth_rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       gnt_o,
   output logic       valid_o
);

   // Winner index from the request pair and the previous grant.
   always_comb begin
      gnt_o = 1'b0;
      case (req_i)
         2'b01:   gnt_o = 1'b0;
         2'b10:   gnt_o = 1'b1;
         2'b11:   gnt_o = ~last_i;
         default: gnt_o = 1'b0;
      endcase
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// Shares one ELBETH RAM port between two requesters, round-robin, one transaction in flight.
// Latency: request sampled in IDLE at t -> mem_enable at t+1 -> mX_ready at t+3; one access per 4 cycles.
// Backpressure: requesters hold their enable until mX_ready; a stuck RAM is abandoned after TIMEOUT WAIT cycles.
module elbeth_mem_arbiter
   import elbeth_mem_arbiter_pkg::*;
#(
   parameter int AW      = MARB_AW,
   parameter int TIMEOUT = MARB_TIMEOUT
) (
   input logic                   clk,
   input logic                   rst,
   elbeth_mem_arbiter_if.master  bus
);

   localparam int            CW      = marb_cnt_width(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   marb_state_e state_q, state_d;
   logic        last_q, last_d;              // requester granted most recently
   logic        gnt_q, gnt_d;                // requester owning the transaction in flight
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;     // WAIT cycles spent so far

   logic               mem_enable_q, mem_enable_d;
   logic [AW-1:0]      mem_addr_q, mem_addr_d;
   logic [MARB_DW-1:0] mem_data_in_q, mem_data_in_d;
   logic [MARB_SW-1:0] mem_rw_q, mem_rw_d;

   logic [1:0]              rdy_q, rdy_d;    // per-requester ready pulse
   logic [1:0]              err_q, err_d;    // per-requester timeout flag
   logic [1:0][MARB_DW-1:0] dout_q, dout_d;  // per-requester read word

   logic pick_gnt;
   logic pick_vld;

   elbeth_rr_pick2 u_pick (
      .req_i   ({bus.m1_enable, bus.m0_enable}),
      .last_i  (last_q),
      .gnt_o   (pick_gnt),
      .valid_o (pick_vld)
   );

   // Saturating increment so the counter can never wrap back into range.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   // Next state and next registered outputs; pulses default to 0 every cycle.
   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      gnt_d         = gnt_q;
      cnt_d         = cnt_q;
      mem_enable_d  = 1'b0;
      mem_rw_d      = '0;
      mem_addr_d    = mem_addr_q;
      mem_data_in_d = mem_data_in_q;
      rdy_d         = '0;
      err_d         = '0;
      dout_d        = '0;

      case (state_q)
         MARB_IDLE: begin
            if (pick_vld) begin
               // Capture straight into the RAM-facing registers so the enable
               // pulse and its fields appear together in the ISSUE cycle.
               gnt_d         = pick_gnt;
               last_d        = pick_gnt;
               mem_enable_d  = 1'b1;
               mem_addr_d    = pick_gnt ? bus.m1_addr    : bus.m0_addr;
               mem_data_in_d = pick_gnt ? bus.m1_data_in : bus.m0_data_in;
               mem_rw_d      = pick_gnt ? bus.m1_rw      : bus.m0_rw;
               cnt_d         = '0;
               state_d       = MARB_ISSUE;
            end
         end
         MARB_ISSUE: begin
            state_d = MARB_WAIT;
         end
         MARB_WAIT: begin
            if (bus.mem_ready) begin
               rdy_d[gnt_q]  = 1'b1;
               dout_d[gnt_q] = bus.mem_data_out;
               state_d       = MARB_RESP;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_MAX) begin
                  // RAM never answered: complete with error and zero data.
                  rdy_d[gnt_q] = 1'b1;
                  err_d[gnt_q] = 1'b1;
                  state_d      = MARB_RESP;
               end
            end
         end
         MARB_RESP: begin
            state_d = MARB_IDLE;
         end
         default: begin
            state_d = MARB_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any transaction without a ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= MARB_IDLE;
         last_q        <= 1'b1;
         gnt_q         <= 1'b0;
         cnt_q         <= '0;
         mem_enable_q  <= 1'b0;
         mem_addr_q    <= '0;
         mem_data_in_q <= '0;
         mem_rw_q      <= '0;
         rdy_q         <= '0;
         err_q         <= '0;
         dout_q        <= '0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         gnt_q         <= gnt_d;
         cnt_q         <= cnt_d;
         mem_enable_q  <= mem_enable_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_in_q <= mem_data_in_d;
         mem_rw_q      <= mem_rw_d;
         rdy_q         <= rdy_d;
         err_q         <= err_d;
         dout_q        <= dout_d;
      end
   end

   assign bus.mem_enable  = mem_enable_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_data_in = mem_data_in_q;
   assign bus.mem_rw      = mem_rw_q;

   assign bus.m0_ready    = rdy_q[0];
   assign bus.m0_error    = err_q[0];
   assign bus.m0_data_out = dout_q[0];
   assign bus.m1_ready    = rdy_q[1];
   assign bus.m1_error    = err_q[1];
   assign bus.m1_data_out = dout_q[1];

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Self-checking bench for elbeth_mem_arbiter: directed vector table, hand-written
// corner sequences (tie, timeout, reset in WAIT) and a randomized run against a
// transaction-level model (busy window, round-robin rule, shadow memory).
`timescale 1ns/1ps
module tb_elbeth_mem_arbiter;

   localparam int AW      = 14;
   localparam int TIMEOUT = 15;
   localparam int NRAND   = 2000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   elbeth_mem_arbiter_if #(.AW(AW)) bif ();

   elbeth_mem_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- RAM environment: read-before-write, 1-cycle ready ----
   logic [31:0] ram [64];
   bit          ram_stuck;
   bit          ld_vld;
   logic [5:0]  ld_addr;
   logic [31:0] ld_dat;

   always @(posedge clk) begin
      logic [31:0] w;
      if (ld_vld) begin
         ram[ld_addr]     <= ld_dat;
         bif.mem_ready    <= 1'b0;
         bif.mem_data_out <= $urandom;
      end else if (bif.mem_enable && !ram_stuck) begin
         w = ram[bif.mem_addr[5:0]];
         bif.mem_ready    <= 1'b1;
         bif.mem_data_out <= w;
         for (int b = 0; b < 4; b++)
            if (bif.mem_rw[b]) w[8*b +: 8] = bif.mem_data_in[8*b +: 8];
         ram[bif.mem_addr[5:0]] <= w;
      end else begin
         bif.mem_ready    <= 1'b0;
         bif.mem_data_out <= $urandom;   // junk: only valid with mem_ready
      end
   end

   // ---------------- shadow memory for the reference model ----------------
   logic [31:0] shadow [64];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic load_word(input logic [5:0] a, input logic [31:0] d);
      ld_vld = 1'b1; ld_addr = a; ld_dat = d;
      shadow[a] = d;
      @(negedge clk);
      ld_vld = 1'b0;
   endtask

   task automatic set_req(input int sel, input logic en, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] rw);
      if (sel == 0) begin
         bif.m0_enable = en; bif.m0_addr = a; bif.m0_data_in = d; bif.m0_rw = rw;
      end else begin
         bif.m1_enable = en; bif.m1_addr = a; bif.m1_data_in = d; bif.m1_rw = rw;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bif.m0_enable = 1'b0;
      bif.m1_enable = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, "_ctl"}, {bif.m0_ready, bif.m0_error, bif.m1_ready, bif.m1_error,
                         bif.mem_enable, bif.mem_rw}, 64'h0);
      chk({nm, "_dout0"}, bif.m0_data_out, 64'h0);
      chk({nm, "_dout1"}, bif.m1_data_out, 64'h0);
      chk({nm, "_maddr"}, bif.mem_addr, 64'h0);
      chk({nm, "_mwdat"}, bif.mem_data_in, 64'h0);
   endtask

   // One transaction from a requester; called at a negedge while the DUT is idle.
   task automatic txn(input int sel, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] rw, input logic [31:0] exp_d, input int exp_lat,
                      input bit exp_err, input string nm);
      int lat;
      bit got, other_bad, spur, rdy_after;
      logic [31:0] dout;
      logic err;
      set_req(sel, 1'b1, a, d, rw);
      lat = 0; got = 0; other_bad = 0; spur = 0; dout = '0; err = 1'b0;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            chk({nm, "_en"},   bif.mem_enable, 64'h1);
            chk({nm, "_addr"}, bif.mem_addr, a);
            chk({nm, "_rw"},   bif.mem_rw, rw);
            chk({nm, "_wdat"}, bif.mem_data_in, d);
         end else if (bif.mem_enable || bif.mem_rw != 4'h0) begin
            spur = 1;
         end
         if (sel == 0) begin
            if (bif.m1_ready || bif.m1_error || bif.m1_data_out != 32'h0) other_bad = 1;
            if (bif.m0_ready) begin got = 1; dout = bif.m0_data_out; err = bif.m0_error; end
         end else begin
            if (bif.m0_ready || bif.m0_error || bif.m0_data_out != 32'h0) other_bad = 1;
            if (bif.m1_ready) begin got = 1; dout = bif.m1_data_out; err = bif.m1_error; end
         end
      end
      set_req(sel, 1'b0, a, d, rw);
      chk({nm, "_ready_seen"}, got, 64'h1);
      chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_data"}, dout, exp_d);
      chk({nm, "_error"}, err, exp_err);
      chk({nm, "_other_quiet"}, other_bad, 64'h0);
      chk({nm, "_no_spurious_en"}, spur, 64'h0);
      @(negedge clk);
      rdy_after = (sel == 0) ? bif.m0_ready : bif.m1_ready;
      chk({nm, "_ready_one_cycle"}, rdy_after, 64'h0);
   endtask

   // Both requesters raise in the same cycle; winner done at +3, loser at +7.
   task automatic tie_test(input int exp_first, input string nm);
      int c0, c1;
      set_req(0, 1'b1, 14'h0010, 32'h0, 4'h0);
      set_req(1, 1'b1, 14'h0020, 32'h0, 4'h0);
      c0 = -1; c1 = -1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (bif.m0_ready && c0 < 0) begin c0 = k; bif.m0_enable = 1'b0; end
         if (bif.m1_ready && c1 < 0) begin c1 = k; bif.m1_enable = 1'b0; end
      end
      bif.m0_enable = 1'b0;
      bif.m1_enable = 1'b0;
      chk({nm, "_m0_cycle"}, c0, (exp_first == 0) ? 3 : 7);
      chk({nm, "_m1_cycle"}, c1, (exp_first == 1) ? 3 : 7);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int          sel;
      logic [13:0] addr;
      logic [31:0] wdata;
      logic [3:0]  rw;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [7];

   // ---------------- random-phase model state ----------------
   bit          ract [2];
   logic [13:0] raddr [2];
   logic [31:0] rwd [2];
   logic [3:0]  rrw [2];
   int          busy, exp_cyc, exp_sel, pct;
   bit          mlast;
   logic [13:0] e_addr;
   logic [31:0] e_wd, e_data;
   logic [3:0]  e_rw;

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit saw;
      bit er0, er1, een, r_seen;
      int win;
      logic [5:0] idx;

      vecs[0] = '{0, 14'h0010, 32'h0,        4'b0000, 32'hDEADBEEF};
      vecs[1] = '{1, 14'h0020, 32'h11223344, 4'b0011, 32'hAABBCCDD};
      vecs[2] = '{1, 14'h0020, 32'h0,        4'b0000, 32'hAABB3344};
      vecs[3] = '{0, 14'h0010, 32'h55667788, 4'b1111, 32'hDEADBEEF};
      vecs[4] = '{0, 14'h0010, 32'h0,        4'b0000, 32'h55667788};
      vecs[5] = '{1, 14'h0020, 32'h99000000, 4'b1000, 32'hAABB3344};
      vecs[6] = '{1, 14'h0020, 32'h0,        4'b0000, 32'h99BB3344};

      rst = 1'b1;
      ram_stuck = 1'b0;
      ld_vld = 1'b0; ld_addr = '0; ld_dat = '0;
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      repeat (3) @(negedge clk);
      chk_quiet("reset");

      load_word(6'h10, 32'hDEADBEEF);
      load_word(6'h20, 32'hAABBCCDD);
      rst = 1'b0;
      @(negedge clk);
      chk_quiet("post_reset_idle");

      // Table: reads, byte-strobed writes, read-before-write data
      for (int i = 0; i < 7; i++)
         txn(vecs[i].sel, vecs[i].addr, vecs[i].wdata, vecs[i].rw, vecs[i].exp_data,
             3, 1'b0, $sformatf("vec%0d", i));

      // Tie after reset: m0 first; after an m0-only access a tie goes to m1
      do_reset();
      tie_test(0, "tie_after_reset");
      txn(0, 14'h0010, 32'h0, 4'h0, 32'h55667788, 3, 1'b0, "tie_prep");
      tie_test(1, "tie_after_m0");

      // RAM never answers: error completion with zero data, then normal again
      ram_stuck = 1'b1;
      txn(0, 14'h0030, 32'h0, 4'h0, 32'h0, TIMEOUT + 2, 1'b1, "timeout");
      ram_stuck = 1'b0;
      txn(1, 14'h0010, 32'h0, 4'h0, 32'h55667788, 3, 1'b0, "after_timeout");

      // Reset while an m0 read is in WAIT
      set_req(0, 1'b1, 14'h0010, 32'h0, 4'h0);
      @(negedge clk);   // ISSUE
      @(negedge clk);   // WAIT
      rst = 1'b1;
      bif.m0_enable = 1'b0;
      @(negedge clk);
      chk_quiet("rst_in_wait");
      rst = 1'b0;
      saw = 0;
      repeat (6) begin
         @(negedge clk);
         if (bif.m0_ready || bif.m1_ready || bif.mem_enable) saw = 1;
      end
      chk("rst_in_wait_no_ready", saw, 64'h0);
      txn(0, 14'h0010, 32'h0, 4'h0, 32'h55667788, 3, 1'b0, "rst_then_read");

      // Randomized traffic against the transaction model
      for (int i = 0; i < 64; i++) load_word(6'(i), $urandom);
      do_reset();
      busy = 0; exp_cyc = -100; exp_sel = 0; mlast = 1'b1;
      e_addr = '0; e_wd = '0; e_data = '0; e_rw = '0;
      for (int r = 0; r < 2; r++) begin
         ract[r] = 0; raddr[r] = '0; rwd[r] = '0; rrw[r] = '0;
      end
      for (int cyc = 0; cyc < NRAND; cyc++) begin
         @(negedge clk);
         pct = (cyc < NRAND / 2) ? 25 : 90;
         er0 = (cyc == exp_cyc) && (exp_sel == 0);
         er1 = (cyc == exp_cyc) && (exp_sel == 1);
         een = (cyc == exp_cyc - 2);
         chk("rnd_m0_ready", bif.m0_ready, er0);
         chk("rnd_m1_ready", bif.m1_ready, er1);
         chk("rnd_m0_dout", bif.m0_data_out, er0 ? e_data : 32'h0);
         chk("rnd_m1_dout", bif.m1_data_out, er1 ? e_data : 32'h0);
         chk("rnd_mem_en", bif.mem_enable, een);
         if (een) begin
            chk("rnd_mem_addr", bif.mem_addr, e_addr);
            chk("rnd_mem_wdat", bif.mem_data_in, e_wd);
            chk("rnd_mem_rw", bif.mem_rw, e_rw);
         end else begin
            chk("rnd_mem_rw_idle", bif.mem_rw, 64'h0);
         end
         if (er0 || er1) chk("rnd_error", bif.m0_error | bif.m1_error, 64'h0);

         if (busy > 0) busy--;

         // Requesters: drop on own ready, maybe raise a fresh request
         for (int r = 0; r < 2; r++) begin
            r_seen = (r == 0) ? bif.m0_ready : bif.m1_ready;
            if (ract[r] && r_seen) ract[r] = 0;
            if (!ract[r] && $urandom_range(0, 99) < pct) begin
               ract[r]  = 1;
               raddr[r] = 14'($urandom);
               rwd[r]   = $urandom;
               rrw[r]   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            end
            set_req(r, ract[r], raddr[r], rwd[r], rrw[r]);
         end

         // Model: accepts only when the previous access window has elapsed
         if (busy == 0 && (ract[0] || ract[1])) begin
            if (ract[0] && ract[1]) win = mlast ? 0 : 1;
            else                    win = ract[0] ? 0 : 1;
            mlast   = (win == 1);
            busy    = 4;
            exp_cyc = cyc + 3;
            exp_sel = win;
            e_addr  = raddr[win];
            e_wd    = rwd[win];
            e_rw    = rrw[win];
            idx     = e_addr[5:0];
            e_data  = shadow[idx];
            for (int b = 0; b < 4; b++)
               if (e_rw[b]) shadow[idx][8*b +: 8] = e_wd[8*b +: 8];
         end
      end
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
